// File: rtl/vote_tally_display.sv
// rtl/vote_tally_display.sv - debounced voter switch tally with LIVE/HOLD latch and 2-digit scanned display
// Ports:
//   clk      - rising-edge clock for all state
//   rst      - synchronous active-high reset
//   comps    - raw voter switches (asynchronous), 1 = vote cast
//   latch    - each rising edge toggles LIVE/HOLD
//   clear    - forces LIVE while high (wins over latch)
//   segs     - {g,f,e,d,c,b,a}, active-low, registered
//   an       - digit enables, active-low; an[0] = units, an[1] = tens; registered
//   majority - displayed count * 2 > N_VOTERS; registered
//   hold     - high in HOLD; registered
module vote_tally_display #(
  parameter int N_VOTERS        = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_VOTERS-1:0] comps,
  input  logic                latch,
  input  logic                clear,
  output logic [6:0]          segs,
  output logic [1:0]          an,
  output logic                majority,
  output logic                hold
);

  localparam int CW = $clog2(N_VOTERS + 1);

  typedef enum logic {LIVE, HOLD} state_t;

  logic [N_VOTERS-1:0] s1;
  logic [N_VOTERS-1:0] s2;
  logic [N_VOTERS-1:0] deb;
  logic [7:0]          deb_cnt [N_VOTERS];
  logic [CW-1:0]       count;
  logic [CW-1:0]       held;
  logic [CW-1:0]       shown;
  logic [15:0]         scan_cnt;
  logic                digit;     // 0 = units slot, 1 = tens slot
  logic                latch_q;
  state_t              state;

  logic [3:0]          shown4;
  logic                tens;
  logic [3:0]          units;
  logic [6:0]          disp_segs;

  function automatic logic [CW-1:0] popcount(input logic [N_VOTERS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_VOTERS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= comps;
      s2 <= s1;
    end
  end

  // Per-bit debounce: a bit is accepted after DEBOUNCE_CYCLES consecutive
  // samples that differ from the accepted value; any agreeing sample restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < N_VOTERS; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_VOTERS; i++) begin
        if (s2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]     <= s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= popcount(deb);
  end

  // Digit scan: the active slot flips each time the divider wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= 1'b0;
    end else if (scan_cnt == 16'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      digit    <= ~digit;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // Count never exceeds 15, so tens is 0 or 1 and a subtract replaces mod/div
  always_comb begin
    shown     = (state == HOLD) ? held : count;
    shown4    = 4'(shown);
    tens      = (shown4 >= 4'd10);
    units     = tens ? (shown4 - 4'd10) : shown4;
    disp_segs = digit ? (tens ? enc(4'd1) : 7'b1111111) : enc(units);
  end

  // LIVE/HOLD state machine with all display outputs registered here so
  // segs and an always move on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LIVE;
      held     <= '0;
      latch_q  <= 1'b0;
      segs     <= 7'b1000000;
      an       <= 2'b10;
      majority <= 1'b0;
      hold     <= 1'b0;
    end else begin
      latch_q  <= latch;
      segs     <= disp_segs;
      an       <= digit ? 2'b01 : 2'b10;
      majority <= ({shown4, 1'b0} > 5'(N_VOTERS));
      hold     <= (state == HOLD);
      if (clear) begin
        state <= LIVE;
      end else if (latch && !latch_q) begin
        case (state)
          LIVE: begin
            state <= HOLD;
            held  <= count;
          end
          default: state <= LIVE;
        endcase
      end
    end
  end

endmodule

// File: doc/vote_tally_display.md
VOTE_TALLY_DISPLAY -- requirements
Module: vote_tally_display

Interface
REQ-001 SHALL have parameter N_VOTERS, default 5, number of voter switches; legal range 1..15.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable samples needed to accept a switch change; legal range 1..255.
REQ-003 SHALL have parameter SCAN_DIV, default 16, clock cycles per digit-scan slot; legal range 1..65535.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 comps  input  N_VOTERS  raw voter switches, asynchronous, 1 = vote cast.
REQ-008 latch  input  1  synchronous level; each rising edge toggles LIVE/HOLD.
REQ-009 clear  input  1  synchronous level; forces LIVE while high.
REQ-010 segs  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 an  output  2  digit enables, active-low; an[0] = units, an[1] = tens; registered.
REQ-012 majority  output  1  high when displayed count * 2 > N_VOTERS; registered.
REQ-013 hold  output  1  high in state HOLD; registered.

Function
REQ-014 SHALL pass each comps bit through a 2-flop synchroniser (s1 -> s2).
REQ-015 SHALL debounce each bit with its own counter: counter clears when s2 == deb; otherwise it increments, and on the DEBOUNCE_CYCLES-th consecutive differing sample deb <= s2 and the counter clears.
REQ-016 SHALL register count = popcount(deb) each cycle, width $clog2(N_VOTERS+1).
REQ-017 Latency: a stable comps change SHALL appear in count exactly 3 + DEBOUNCE_CYCLES rising edges after the change is set up (7 at defaults); a glitch shorter than DEBOUNCE_CYCLES samples at s2 SHALL have no effect.
REQ-018 FSM states SHALL be LIVE and HOLD; shown = count in LIVE, and shown = held in HOLD.
REQ-019 LIVE -> HOLD SHALL occur on a latch rising edge (latch high, previous latch low); held <= count on the same edge.
REQ-020 HOLD -> LIVE SHALL occur on a latch rising edge or whenever clear is high.
REQ-021 clear high together with a latch rising edge SHALL leave/keep LIVE; clear wins.
REQ-022 latch held high SHALL cause only one toggle; a new toggle requires latch to return low first.
REQ-023 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap the active digit toggles between units and tens.
REQ-024 Display values: units = shown mod 10, tens = shown / 10 (0 or 1).
REQ-025 The tens digit SHALL be blank (segs = 1111111) when tens == 0.
REQ-026 Digit encodings (g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-027 segs, an, majority and hold SHALL update 1 cycle after shown, scan digit or state change; segs and an SHALL always switch on the same edge, with no overlap.
REQ-028 majority SHALL be computed from shown, so it freezes in HOLD.

Reset
REQ-029 rst high at a clock edge SHALL clear s1, s2, deb, debounce counters, count, held, scan counter and latch history, and SHALL select state LIVE with the units digit active.
REQ-030 Outputs during and immediately after reset SHALL be: segs = 1000000, an = 10, majority = 0, hold = 0.
REQ-031 Reset mid-debounce or in HOLD SHALL discard all partial and held state; switches already high SHALL re-debounce from zero.

Verification
REQ-032 Defaults; set comps = 5'b10110 after reset -> count = 3 after 7 edges; units segs = 0110000; tens blank; majority = 1.
REQ-033 Glitch: a 3-cycle pulse on comps[0] -> count stays 0; a 4-cycle stable pulse -> count = 1 at +7 edges.
REQ-034 Hold: count = 3, latch rising edge, then comps = 0 -> hold = 1, units digit stays 3, majority stays 1; second latch rising edge -> display shows 0, majority = 0.
REQ-035 N_VOTERS = 12, all comps high -> tens digit 1111001, units digit 0100100, an alternates every SCAN_DIV cycles, majority = 1.
REQ-036 Conflict: in HOLD, assert latch rise and clear on the same cycle -> state LIVE, hold = 0; holding latch high 10 cycles -> no further toggle.
REQ-037 rst pulse while in HOLD with comps = all-high -> outputs match REQ-030 next cycle; count returns to N_VOTERS 7 edges after rst deasserts.
